pingpong_frame_sched: RTL and testbench

Ping-pong scheduler for the two-half preprocessing frame buffer (`bram_double_part`). It launches the producer chain (frame reader → gaussian) whenever a bank is free. It generates the buffer write enable and address from the gaussian output strobe. It hands each completed bank to the downstream consumer (encoder/SNN input) and recycles the bank once the consumer reports it is finished. It sits between the control FSM's preprocess start and the buffer, so producing the next frame overlaps with consuming the current one.

---
 rtl/pingpong_frame_sched.sv | 170 +++++++++++++++++
 tb/tb_pingpong_frame_sched.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pingpong_frame_sched.sv
// pingpong_frame_sched
// Ping-pong scheduler for the two-half preprocessing frame buffer.
// The producer side launches the frame reader/gaussian chain into a free bank
// and generates buffer write strobes/addresses from the gaussian pixel strobe.
// The consumer side hands each full bank downstream and recycles it once the
// consumer releases it, so filling one bank overlaps with reading the other.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   run               level; allows new producer frames to be launched
//   prod_start        1-cycle pulse, start producer for one frame
//   wr_valid          gaussian pixel strobe
//   wr_frame_end      gaussian frame-end marker (with last wr_valid)
//   bram_wr_en        buffer port-B write enable (combinational from wr_valid)
//   bram_wr_addr      buffer port-B write address
//   cons_start        1-cycle pulse, bank at cons_base is full and handed over
//   cons_base         base address of the consumer's bank
//   cons_done         pulse, consumer released its bank
//   bank_full         bit b set while bank b is FULL or READING
//   frames_written    completed frame count (wraps)
//   overflow          sticky, pixel arrived with no bank filling
//   frame_err         sticky, frame-end marker and pixel count disagreed
module pingpong_frame_sched #(
    parameter int IMG_WIDTH  = 220,
    parameter int IMG_HEIGHT = 168,
    parameter int ADDR_WIDTH = 17
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run,
    output logic                  prod_start,
    input  logic                  wr_valid,
    input  logic                  wr_frame_end,
    output logic                  bram_wr_en,
    output logic [ADDR_WIDTH-1:0] bram_wr_addr,
    output logic                  cons_start,
    output logic [ADDR_WIDTH-1:0] cons_base,
    input  logic                  cons_done,
    output logic [1:0]            bank_full,
    output logic [15:0]           frames_written,
    output logic                  overflow,
    output logic                  frame_err
);

    // state      | meaning
    // P_IDLE     | producer waiting for run and an EMPTY bank at wbank
    // P_FILL     | producer writing gaussian pixels into bank wbank
    // C_IDLE     | consumer waiting for bank rbank to become FULL
    // C_BUSY     | consumer owns bank rbank until cons_done
    // B_EMPTY    | bank free for the producer
    // B_FILLING  | bank being written
    // B_FULL     | bank complete, not yet handed over
    // B_READING  | bank owned by the consumer

    localparam int FRAME_PIXELS = IMG_WIDTH * IMG_HEIGHT;
    localparam logic [ADDR_WIDTH-1:0] LAST_PIX   = ADDR_WIDTH'(FRAME_PIXELS - 1);
    localparam logic [ADDR_WIDTH-1:0] BANK1_BASE = ADDR_WIDTH'(FRAME_PIXELS);

    typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_READING} bank_st_t;
    typedef enum logic {P_IDLE, P_FILL} p_st_t;
    typedef enum logic {C_IDLE, C_BUSY} c_st_t;

    bank_st_t              bank_q [2];
    bank_st_t              bank_d [2];
    bank_st_t              bank_mid [2];
    p_st_t                 p_st_q, p_st_d;
    c_st_t                 c_st_q, c_st_d;
    logic                  wbank_q, wbank_d;
    logic                  rbank_q, rbank_d;
    logic [ADDR_WIDTH-1:0] wcnt_q, wcnt_d;
    logic                  prod_start_q, prod_start_d;
    logic                  cons_start_q, cons_start_d;
    logic [ADDR_WIDTH-1:0] cons_base_q, cons_base_d;
    logic [15:0]           frames_q, frames_d;
    logic                  overflow_q, overflow_d;
    logic                  frame_err_q, frame_err_d;

    logic wr_acc, at_last, p_complete, c_release, p_launch, c_launch;

    always_comb begin
        wr_acc     = (p_st_q == P_FILL) && wr_valid;
        at_last    = (wcnt_q == LAST_PIX);
        p_complete = wr_acc && (at_last || wr_frame_end);
        c_release  = (c_st_q == C_BUSY) && cons_done;

        // Completion and release are applied first so that a bank freed or
        // filled this cycle can be relaunched by the other side without an
        // idle cycle; the pulses then appear one cycle after the event.
        bank_mid = bank_q;
        if (p_complete) bank_mid[wbank_q] = B_FULL;
        if (c_release)  bank_mid[rbank_q] = B_EMPTY;
        wbank_d = wbank_q ^ p_complete;
        rbank_d = rbank_q ^ c_release;

        p_launch = ((p_st_q == P_IDLE) || p_complete) && run &&
                   (bank_mid[wbank_d] == B_EMPTY);
        c_launch = ((c_st_q == C_IDLE) || c_release) &&
                   (bank_mid[rbank_d] == B_FULL);

        // A launch needs EMPTY vs FULL, so both can never hit the same bank.
        bank_d = bank_mid;
        if (p_launch) bank_d[wbank_d] = B_FILLING;
        if (c_launch) bank_d[rbank_d] = B_READING;

        p_st_d = p_st_q;
        if (p_launch)        p_st_d = P_FILL;
        else if (p_complete) p_st_d = P_IDLE;

        wcnt_d = wcnt_q;
        if (p_launch || p_complete) wcnt_d = '0;
        else if (wr_acc)            wcnt_d = wcnt_q + 1'b1;

        c_st_d = c_st_q;
        if (c_launch)       c_st_d = C_BUSY;
        else if (c_release) c_st_d = C_IDLE;

        cons_base_d = cons_base_q;
        if (c_launch) cons_base_d = rbank_d ? BANK1_BASE : '0;

        prod_start_d = p_launch;
        cons_start_d = c_launch;
        frames_d     = frames_q + 16'(p_complete);
        overflow_d   = overflow_q || (wr_valid && (p_st_q != P_FILL));
        frame_err_d  = frame_err_q || (wr_acc && (wr_frame_end != at_last));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_q[0]    <= B_EMPTY;
            bank_q[1]    <= B_EMPTY;
            p_st_q       <= P_IDLE;
            c_st_q       <= C_IDLE;
            wbank_q      <= 1'b0;
            rbank_q      <= 1'b0;
            wcnt_q       <= '0;
            prod_start_q <= 1'b0;
            cons_start_q <= 1'b0;
            cons_base_q  <= '0;
            frames_q     <= '0;
            overflow_q   <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            bank_q[0]    <= bank_d[0];
            bank_q[1]    <= bank_d[1];
            p_st_q       <= p_st_d;
            c_st_q       <= c_st_d;
            wbank_q      <= wbank_d;
            rbank_q      <= rbank_d;
            wcnt_q       <= wcnt_d;
            prod_start_q <= prod_start_d;
            cons_start_q <= cons_start_d;
            cons_base_q  <= cons_base_d;
            frames_q     <= frames_d;
            overflow_q   <= overflow_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign prod_start     = prod_start_q;
    assign cons_start     = cons_start_q;
    assign cons_base      = cons_base_q;
    assign bram_wr_en     = wr_acc;
    assign bram_wr_addr   = (wbank_q ? BANK1_BASE : '0) + wcnt_q;
    assign bank_full[0]   = (bank_q[0] == B_FULL) || (bank_q[0] == B_READING);
    assign bank_full[1]   = (bank_q[1] == B_FULL) || (bank_q[1] == B_READING);
    assign frames_written = frames_q;
    assign overflow       = overflow_q;
    assign frame_err      = frame_err_q;

endmodule

// File: tb/tb_pingpong_frame_sched.sv
// Testbench for pingpong_frame_sched. Uses a reduced frame size (22x12) so
// several full ping-pong rounds fit in a short run.
module tb_pingpong_frame_sched;

    localparam int W  = 22;
    localparam int H  = 12;
    localparam int AW = 17;
    localparam int FP = W * H;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          run = 1'b0;
    logic          wr_valid = 1'b0;
    logic          wr_frame_end = 1'b0;
    logic          cons_done = 1'b0;
    logic          prod_start, bram_wr_en, cons_start, overflow, frame_err;
    logic [AW-1:0] bram_wr_addr, cons_base;
    logic [1:0]    bank_full;
    logic [15:0]   frames_written;

    int n_tests = 0;
    int n_fail  = 0;
    int p_cnt   = 0;
    int wr_q[$];
    int cons_q[$];

    pingpong_frame_sched #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .prod_start(prod_start),
        .wr_valid(wr_valid), .wr_frame_end(wr_frame_end),
        .bram_wr_en(bram_wr_en), .bram_wr_addr(bram_wr_addr),
        .cons_start(cons_start), .cons_base(cons_base), .cons_done(cons_done),
        .bank_full(bank_full), .frames_written(frames_written),
        .overflow(overflow), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives npix pixels for a bank at base; wr_frame_end goes with index end_at.
    task automatic send_frame(input int base, input int npix, input int end_at);
        for (int i = 0; i < npix; i++) begin
            wr_valid     = 1'b1;
            wr_frame_end = (i == end_at);
            wr_q.push_back(base + i);
            cyc();
        end
        wr_valid     = 1'b0;
        wr_frame_end = 1'b0;
    endtask

    task automatic pulse_done();
        cons_done = 1'b1;
        cyc();
        cons_done = 1'b0;
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_prod_start"}, prod_start, 0);
        chk({pfx, "_cons_start"}, cons_start, 0);
        chk({pfx, "_wr_en"}, bram_wr_en, 0);
        chk({pfx, "_wr_addr"}, bram_wr_addr, 0);
        chk({pfx, "_cons_base"}, cons_base, 0);
        chk({pfx, "_bank_full"}, bank_full, 0);
        chk({pfx, "_frames"}, frames_written, 0);
        chk({pfx, "_overflow"}, overflow, 0);
        chk({pfx, "_frame_err"}, frame_err, 0);
    endtask

    // Scoreboard: every write and every consumer handover is matched
    // against the expectation queued when the stimulus was driven.
    always @(negedge clk) begin
        if (rst_n) begin
            if (prod_start) p_cnt++;
            if (bram_wr_en) begin
                if (wr_q.size() == 0) chk("wr_unexpected", 1, 0);
                else chk("wr_addr", bram_wr_addr, wr_q.pop_front());
            end
            if (cons_start) begin
                if (cons_q.size() == 0) chk("cons_unexpected", 1, 0);
                else chk("cons_base", cons_base, cons_q.pop_front());
            end
        end
    end

    initial begin
        #3;
        chk_all_zero("rst");
        cyc(2);
        rst_n = 1'b1;
        cyc();
        run = 1'b1;
        cyc();
        chk("first_prod_start", prod_start, 1);

        // frame 1 into bank 0
        cyc(2);
        cons_q.push_back(0);
        send_frame(0, FP, FP - 1);
        chk("f1_cons_start", cons_start, 1);
        chk("f1_cons_base", cons_base, 0);
        chk("f1_prod_start_b1", prod_start, 1);
        chk("f1_frames", frames_written, 1);
        chk("f1_bank_full", bank_full, 2'b01);

        // frame 2 into bank 1 while consumer holds bank 0
        cyc(3);
        send_frame(FP, FP, FP - 1);
        chk("f2_prod_start", prod_start, 0);
        chk("f2_cons_start", cons_start, 0);
        chk("f2_bank_full", bank_full, 2'b11);
        chk("f2_frames", frames_written, 2);
        cyc(5);
        chk("f2_no_third_prod", p_cnt, 2);

        // release bank 0: producer relaunches, consumer takes bank 1
        cons_q.push_back(FP);
        pulse_done();
        chk("rel0_prod_start", prod_start, 1);
        chk("rel0_cons_start", cons_start, 1);
        chk("rel0_cons_base", cons_base, FP);
        chk("rel0_bank_full", bank_full, 2'b10);

        // frame 3 into bank 0, then a stray pixel while idle
        cyc(2);
        send_frame(0, FP, FP - 1);
        chk("f3_frames", frames_written, 3);
        chk("f3_bank_full", bank_full, 2'b11);
        chk("f3_prod_start", prod_start, 0);
        chk("f3_overflow_pre", overflow, 0);
        wr_valid = 1'b1;
        @(negedge clk);
        chk("ovf_wr_en", bram_wr_en, 0);
        cyc();
        wr_valid = 1'b0;
        chk("ovf_set", overflow, 1);
        cyc(3);
        chk("ovf_sticky", overflow, 1);
        chk("frame_err_clean", frame_err, 0);

        // release bank 1: producer fills bank 1, consumer takes bank 0
        cons_q.push_back(0);
        pulse_done();
        chk("rel1_prod_start", prod_start, 1);
        chk("rel1_cons_start", cons_start, 1);
        chk("rel1_bank_full", bank_full, 2'b01);
        cyc(2);
        pulse_done();
        chk("rel0b_cons_start", cons_start, 0);
        chk("rel0b_bank_full", bank_full, 2'b00);

        // early frame end at pixel 100 into bank 1
        cons_q.push_back(FP);
        send_frame(FP, 101, 100);
        chk("early_frame_err", frame_err, 1);
        chk("early_cons_start", cons_start, 1);
        chk("early_prod_start", prod_start, 1);
        chk("early_bank_full", bank_full, 2'b10);
        chk("early_frames", frames_written, 4);

        // async reset mid-frame in bank 0
        cyc(2);
        send_frame(0, 50, -1);
        wr_valid = 1'b1;
        rst_n    = 1'b0;
        #1;
        chk_all_zero("arst");
        wr_valid = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        cyc();
        chk("post_rst_prod_start", prod_start, 1);
        chk("post_rst_frames", frames_written, 0);
        wr_valid = 1'b1;
        wr_q.push_back(0);
        @(negedge clk);
        chk("post_rst_addr", bram_wr_addr, 0);
        cyc();
        wr_valid = 1'b0;
        cyc(2);
        chk("wr_q_drained", wr_q.size(), 0);
        chk("cons_q_drained", cons_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
